plot_sink: RTL

- Receiving end of the pixel-plot interface driven by the grid and tile drawers (x, y, colour, plot).
- Buffers plot requests in a small FIFO, range-checks them, and converts each to a linear framebuffer write (addr = y*SCREEN_W + x) on a stallable memory port.
- Provides a full-screen clear sequence. Sits between the drawing blocks and the VGA adapter video RAM.

---
 rtl/plot_sink_pkg.sv | 23 ++
 rtl/plot_sink_fifo.sv | 55 +++++
 rtl/plot_sink.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/plot_sink_pkg.sv
// Shared definitions for the pixel-plot sink: screen geometry, colours,
// controller states and the layout of a buffered plot entry.
package plot_sink_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOUR_W     = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } sink_state_t;

  // A buffered entry is the concatenation {x, y, colour}, x in the MSBs.
  function automatic int entry_width(input int x_w, input int y_w);
    return x_w + y_w + COLOUR_W;
  endfunction

endpackage

// File: rtl/plot_sink_fifo.sv
// Small synchronous FIFO holding accepted plot requests; the head entry is
// visible combinationally so the drain side never spends a cycle on a read.
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

  assign head_data = storage[rd_ptr];

endmodule

// File: rtl/plot_sink.sv
// Plot sink: buffers pixel plots, range-checks them and writes them to the
// framebuffer as linear addresses, with a full-screen clear sequence.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int                  DEPTH        = 8,
  parameter int                  SCREEN_W     = SCREEN_W_DEF,
  parameter int                  SCREEN_H     = SCREEN_H_DEF,
  parameter int                  X_W          = 8,
  parameter int                  Y_W          = 7,
  parameter int                  ADDR_W       = 15,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = COLOUR_BLACK
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [X_W-1:0]      plot_x,
  input  logic [Y_W-1:0]      plot_y,
  input  logic [COLOUR_W-1:0] plot_colour,
  input  logic                plot_valid,
  output logic                plot_ready,
  input  logic                clear_req,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [7:0]          drop_count
);

  localparam int                ENTRY_W   = entry_width(X_W, Y_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  sink_state_t         state;
  sink_state_t         state_next;
  logic [ADDR_W-1:0]   clear_cnt;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_head;

  logic [X_W-1:0]      head_x;
  logic [Y_W-1:0]      head_y;
  logic [COLOUR_W-1:0] head_colour;
  logic [ADDR_W-1:0]   x_ext;
  logic [ADDR_W-1:0]   y_ext;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   drain_addr;

  logic                in_range;
  logic                plot_accept;
  logic                drop_inc;

  assign in_range    = (32'(plot_x) < 32'(SCREEN_W)) && (32'(plot_y) < 32'(SCREEN_H));
  assign plot_accept = plot_valid && plot_ready;
  assign fifo_push   = plot_accept && in_range;
  assign drop_inc    = plot_accept && !in_range;

  plot_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .push_data ({plot_x, plot_y, plot_colour}),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_x      = fifo_head[ENTRY_W-1 -: X_W];
  assign head_y      = fifo_head[COLOUR_W +: Y_W];
  assign head_colour = fifo_head[COLOUR_W-1:0];
  assign x_ext       = ADDR_W'(head_x);
  assign y_ext       = ADDR_W'(head_y);

  // 160 = 128 + 32, so the default row width needs only shifts and one add.
  generate
    if (SCREEN_W == 160) begin : g_row_shift
      assign row_base = (y_ext << 7) + (y_ext << 5);
    end else begin : g_row_mult
      assign row_base = y_ext * ADDR_W'(SCREEN_W);
    end
  endgenerate

  assign drain_addr = row_base + x_ext;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    plot_ready = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      ST_RUN: begin
        plot_ready = !fifo_full && !clear_req;
        if (!fifo_empty) begin
          mem_we   = 1'b1;
          mem_addr = drain_addr;
          mem_data = head_colour;
          fifo_pop = mem_ready;
        end
        if (clear_req) begin
          fifo_flush = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clear_cnt;
        mem_data = CLEAR_COLOUR;
        if (mem_ready && (clear_cnt == LAST_ADDR)) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // The clear address only advances when the memory takes the write.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (clear_req) clear_cnt <= '0;
    end else if (mem_ready) begin
      clear_cnt <= (clear_cnt == LAST_ADDR) ? '0 : clear_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                               drop_count <= '0;
    else if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end

endmodule
